// File: rtl/position_pkg.sv
// Shared types and constants for the 3x3 board cursor/commit path.
// Cell index is row*GRID_DIM+col, carried as pos_t on every consumer.
package position_pkg;

  localparam int GRID_DIM  = 3;
  localparam int NUM_CELLS = GRID_DIM * GRID_DIM;

  typedef logic [3:0] pos_t;

  typedef enum logic {
    SELECT = 1'b0,
    HOLD   = 1'b1
  } sel_state_t;

  function automatic pos_t to_index(input logic [1:0] row, input logic [1:0] col);
    return pos_t'(row) * pos_t'(GRID_DIM) + pos_t'(col);
  endfunction

endpackage

// File: rtl/position_selector_if.sv
// Commit handshake bundle: selector drives cursor/pos_out/pos_valid/sel_err,
// the board decoder returns pos_ack; pos_out is stable while pos_valid is high.
interface position_selector_if;
  import position_pkg::*;

  pos_t cursor;
  pos_t pos_out;
  logic pos_valid;
  logic pos_ack;
  logic sel_err;

  modport master (
    output cursor,
    output pos_out,
    output pos_valid,
    output sel_err,
    input  pos_ack
  );

  modport slave (
    input  cursor,
    input  pos_out,
    input  pos_valid,
    input  sel_err,
    output pos_ack
  );

endinterface

// File: rtl/btn_edge.sv
// Rising-edge detector for one clk-synchronous button level; combinational act.
// prev resets to 1 so a button held through reset never yields an action.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic act
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= btn;
  end

  assign act = btn & ~prev_q;

endmodule

// File: rtl/position_selector.sv
// Cursor selector/committer: one cycle from button edge to registered output; HOLD keeps pos_valid until pos_ack.
// POSITION_WRAP_EN defined: row/col wrap modulo 3; undefined: moves saturate at the board edge.
module position_selector
  import position_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_sel,
  input  logic [NUM_CELLS-1:0] occupied,
  position_selector_if.master  pif
);

  function automatic logic [1:0] step_inc(input logic [1:0] v);
`ifdef POSITION_WRAP_EN
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
`else
    return (v == 2'd2) ? 2'd2 : v + 2'd1;
`endif
  endfunction

  function automatic logic [1:0] step_dec(input logic [1:0] v);
`ifdef POSITION_WRAP_EN
    return (v == 2'd0) ? 2'd2 : v - 2'd1;
`else
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
`endif
  endfunction

  logic act_up, act_down, act_left, act_right, act_sel;

  btn_edge u_edge_up    (.clk(clk), .rst(rst), .btn(btn_up),    .act(act_up));
  btn_edge u_edge_down  (.clk(clk), .rst(rst), .btn(btn_down),  .act(act_down));
  btn_edge u_edge_left  (.clk(clk), .rst(rst), .btn(btn_left),  .act(act_left));
  btn_edge u_edge_right (.clk(clk), .rst(rst), .btn(btn_right), .act(act_right));
  btn_edge u_edge_sel   (.clk(clk), .rst(rst), .btn(btn_sel),   .act(act_sel));

  sel_state_t state_q, state_d;
  logic [1:0] row_q, row_d, col_q, col_d;
  pos_t       pos_q, pos_d;
  logic       vld_q, vld_d;
  logic       err_q, err_d;
  pos_t       cur;

  assign cur = to_index(row_q, col_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SELECT;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      pos_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pos_q   <= pos_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  // Priority chain drops lower-priority edges that arrive in the same cycle.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    pos_d   = pos_q;
    vld_d   = vld_q;
    err_d   = 1'b0;
    case (state_q)
      SELECT: begin
        if (enable) begin
          if (act_sel) begin
            if (occupied[cur]) begin
              err_d = 1'b1;
            end else begin
              pos_d   = cur;
              vld_d   = 1'b1;
              state_d = HOLD;
            end
          end else if (act_up) begin
            row_d = step_dec(row_q);
          end else if (act_down) begin
            row_d = step_inc(row_q);
          end else if (act_left) begin
            col_d = step_dec(col_q);
          end else if (act_right) begin
            col_d = step_inc(col_q);
          end
        end
      end
      HOLD: begin
        if (pif.pos_ack) begin
          vld_d   = 1'b0;
          state_d = SELECT;
        end
      end
      default: begin
        state_d = SELECT;
      end
    endcase
  end

  assign pif.cursor    = cur;
  assign pif.pos_out   = pos_q;
  assign pif.pos_valid = vld_q;
  assign pif.sel_err   = err_q;

endmodule

// File: tb/tb_position_selector.sv
// Directed self-checking bench for position_selector; expected values are hand-computed.
module tb_position_selector;
  import position_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b1;
  logic [4:0] btn = 5'b0;   // {sel, up, down, left, right}
  logic [8:0] occupied = 9'b0;
  int         tests = 0;
  int         fails = 0;

  position_selector_if pif ();

  position_selector dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .btn_up    (btn[3]),
    .btn_down  (btn[2]),
    .btn_left  (btn[1]),
    .btn_right (btn[0]),
    .btn_sel   (btn[4]),
    .occupied  (occupied),
    .pif       (pif.master)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] B_SEL = 5'b10000, B_UP = 5'b01000, B_DOWN = 5'b00100,
                         B_LEFT = 5'b00010, B_RIGHT = 5'b00001;

  task automatic do_reset();
    @(negedge clk);
    btn = 5'b0; rst = 1'b1; pif.pos_ack = 1'b0; enable = 1'b1; occupied = 9'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Idle edge with buttons low, then one edge carrying the pattern; returns after that edge.
  task automatic pulse(input logic [4:0] pat);
    @(negedge clk);
    btn = pat;
    @(negedge clk);
    btn = 5'b0;
  endtask

  task automatic go_to_4();
    pulse(B_DOWN);
    pulse(B_RIGHT);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; pif.pos_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (pif.cursor !== 4'd0) begin $display("FAIL reset_cursor got %0d exp 0", pif.cursor); fails++; end
    tests++;
    if (pif.pos_out !== 4'd0) begin $display("FAIL reset_pos_out got %0d exp 0", pif.pos_out); fails++; end
    tests++;
    if (pif.pos_valid !== 1'b0) begin $display("FAIL reset_pos_valid got %b exp 0", pif.pos_valid); fails++; end
    tests++;
    if (pif.sel_err !== 1'b0) begin $display("FAIL reset_sel_err got %b exp 0", pif.sel_err); fails++; end
    tests++;
    rst = 1'b0;
  endtask

  task automatic test_move();
    pos_t exp_edge;
`ifdef POSITION_WRAP_EN
    exp_edge = 4'd3;
`else
    exp_edge = 4'd5;
`endif
    do_reset();
    pulse(B_RIGHT);
    if (pif.cursor !== 4'd1) begin $display("FAIL move_right1 got %0d exp 1", pif.cursor); fails++; end
    tests++;
    pulse(B_RIGHT);
    if (pif.cursor !== 4'd2) begin $display("FAIL move_right2 got %0d exp 2", pif.cursor); fails++; end
    tests++;
    pulse(B_DOWN);
    if (pif.cursor !== 4'd5) begin $display("FAIL move_down got %0d exp 5", pif.cursor); fails++; end
    tests++;
    pulse(B_RIGHT);
    if (pif.cursor !== exp_edge) begin $display("FAIL move_edge got %0d exp %0d", pif.cursor, exp_edge); fails++; end
    tests++;
    // Held button: exactly one action.
    do_reset();
    @(negedge clk);
    btn = B_DOWN;
    repeat (4) @(negedge clk);
    btn = 5'b0;
    if (pif.cursor !== 4'd3) begin $display("FAIL move_held got %0d exp 3", pif.cursor); fails++; end
    tests++;
    pulse(B_UP);
    if (pif.cursor !== 4'd0) begin $display("FAIL move_up got %0d exp 0", pif.cursor); fails++; end
    tests++;
    pulse(B_LEFT);
`ifdef POSITION_WRAP_EN
    if (pif.cursor !== 4'd2) begin $display("FAIL move_left_edge got %0d exp 2", pif.cursor); fails++; end
`else
    if (pif.cursor !== 4'd0) begin $display("FAIL move_left_edge got %0d exp 0", pif.cursor); fails++; end
`endif
    tests++;
  endtask

  task automatic test_commit();
    do_reset();
    go_to_4();
    if (pif.cursor !== 4'd4) begin $display("FAIL commit_cursor got %0d exp 4", pif.cursor); fails++; end
    tests++;
    pulse(B_SEL);
    if (pif.pos_valid !== 1'b1 || pif.pos_out !== 4'd4) begin
      $display("FAIL commit_first got valid=%b pos=%0d exp valid=1 pos=4", pif.pos_valid, pif.pos_out); fails++;
    end
    tests++;
    repeat (2) begin
      @(negedge clk);
      if (pif.pos_valid !== 1'b1 || pif.pos_out !== 4'd4) begin
        $display("FAIL commit_hold got valid=%b pos=%0d exp valid=1 pos=4", pif.pos_valid, pif.pos_out); fails++;
      end
      tests++;
    end
    pif.pos_ack = 1'b1;
    @(negedge clk);
    pif.pos_ack = 1'b0;
    if (pif.pos_valid !== 1'b0 || pif.pos_out !== 4'd4) begin
      $display("FAIL commit_ack got valid=%b pos=%0d exp valid=0 pos=4", pif.pos_valid, pif.pos_out); fails++;
    end
    tests++;
    // Earliest new commit: sel edge on the cycle right after the ack edge.
    btn = B_SEL;
    @(negedge clk);
    btn = 5'b0;
    if (pif.pos_valid !== 1'b1) begin $display("FAIL commit_rearm got %b exp 1", pif.pos_valid); fails++; end
    tests++;
    pif.pos_ack = 1'b1;
    @(negedge clk);
    // Stray ack while idle must not disturb anything.
    @(negedge clk);
    pif.pos_ack = 1'b0;
    if (pif.pos_valid !== 1'b0 || pif.cursor !== 4'd4) begin
      $display("FAIL commit_stray_ack got valid=%b cursor=%0d exp valid=0 cursor=4", pif.pos_valid, pif.cursor); fails++;
    end
    tests++;
  endtask

  task automatic test_occupied();
    do_reset();
    go_to_4();
    occupied = 9'b000010000;
    pulse(B_SEL);
    if (pif.sel_err !== 1'b1 || pif.pos_valid !== 1'b0) begin
      $display("FAIL occ_err got err=%b valid=%b exp err=1 valid=0", pif.sel_err, pif.pos_valid); fails++;
    end
    tests++;
    @(negedge clk);
    if (pif.sel_err !== 1'b0 || pif.cursor !== 4'd4) begin
      $display("FAIL occ_pulse got err=%b cursor=%0d exp err=0 cursor=4", pif.sel_err, pif.cursor); fails++;
    end
    tests++;
    // Still in SELECT: a free cell now commits.
    pulse(B_RIGHT);
    pulse(B_SEL);
    if (pif.pos_valid !== 1'b1 || pif.pos_out !== 4'd5 || pif.sel_err !== 1'b0) begin
      $display("FAIL occ_select got valid=%b pos=%0d err=%b exp valid=1 pos=5 err=0",
               pif.pos_valid, pif.pos_out, pif.sel_err); fails++;
    end
    tests++;
  endtask

  task automatic test_priority();
    do_reset();
    go_to_4();
    pulse(B_SEL | B_UP | B_LEFT);
    if (pif.pos_valid !== 1'b1 || pif.pos_out !== 4'd4 || pif.cursor !== 4'd4) begin
      $display("FAIL prio got valid=%b pos=%0d cursor=%0d exp valid=1 pos=4 cursor=4",
               pif.pos_valid, pif.pos_out, pif.cursor); fails++;
    end
    tests++;
    pif.pos_ack = 1'b1;
    @(negedge clk);
    pif.pos_ack = 1'b0;
    pulse(B_UP | B_LEFT | B_RIGHT);
    if (pif.cursor !== 4'd1) begin $display("FAIL prio_move got %0d exp 1", pif.cursor); fails++; end
    tests++;
  endtask

  task automatic test_hold();
    do_reset();
    go_to_4();
    pulse(B_SEL);
    pulse(B_RIGHT);
    enable = 1'b0;
    pulse(B_SEL);
    enable = 1'b1;
    pulse(B_DOWN | B_SEL);
    if (pif.cursor !== 4'd4 || pif.pos_out !== 4'd4 || pif.pos_valid !== 1'b1) begin
      $display("FAIL hold_ignore got cursor=%0d pos=%0d valid=%b exp cursor=4 pos=4 valid=1",
               pif.cursor, pif.pos_out, pif.pos_valid); fails++;
    end
    tests++;
    // sel edge coinciding with ack is sampled in HOLD and dropped.
    @(negedge clk);
    pif.pos_ack = 1'b1; btn = B_SEL;
    @(negedge clk);
    pif.pos_ack = 1'b0;
    if (pif.pos_valid !== 1'b0) begin $display("FAIL hold_ack_sel got %b exp 0", pif.pos_valid); fails++; end
    tests++;
    @(negedge clk);
    btn = 5'b0;
    if (pif.pos_valid !== 1'b0) begin $display("FAIL hold_no_recommit got %b exp 0", pif.pos_valid); fails++; end
    tests++;
    enable = 1'b0;
    pulse(B_RIGHT);
    pulse(B_SEL);
    if (pif.cursor !== 4'd4 || pif.pos_valid !== 1'b0) begin
      $display("FAIL disabled got cursor=%0d valid=%b exp cursor=4 valid=0", pif.cursor, pif.pos_valid); fails++;
    end
    tests++;
    enable = 1'b1;
  endtask

  task automatic test_reset_hold();
    do_reset();
    pulse(B_DOWN);
    pulse(B_SEL);
    if (pif.pos_valid !== 1'b1 || pif.pos_out !== 4'd3) begin
      $display("FAIL rh_commit got valid=%b pos=%0d exp valid=1 pos=3", pif.pos_valid, pif.pos_out); fails++;
    end
    tests++;
    @(negedge clk);
    rst = 1'b1; btn = B_DOWN;
    @(negedge clk);
    if (pif.pos_valid !== 1'b0 || pif.pos_out !== 4'd0 || pif.cursor !== 4'd0 || pif.sel_err !== 1'b0) begin
      $display("FAIL rh_reset got valid=%b pos=%0d cursor=%0d err=%b exp all 0",
               pif.pos_valid, pif.pos_out, pif.cursor, pif.sel_err); fails++;
    end
    tests++;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    btn = 5'b0;
    @(negedge clk);
    if (pif.cursor !== 4'd0 || pif.pos_valid !== 1'b0) begin
      $display("FAIL rh_held_down got cursor=%0d valid=%b exp cursor=0 valid=0", pif.cursor, pif.pos_valid); fails++;
    end
    tests++;
    pulse(B_DOWN);
    if (pif.cursor !== 4'd3) begin $display("FAIL rh_after got %0d exp 3", pif.cursor); fails++; end
    tests++;
  endtask

  initial begin
    pif.pos_ack = 1'b0;
    test_reset();
    test_move();
    test_commit();
    test_occupied();
    test_priority();
    test_hold();
    test_reset_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
